fp16_sequential_subtractor: RTL and testbench

- Multi-cycle FP16 magnitude subtractor: result = |A| - |B|. It is the inverse operation of the team's combinational same-sign FP16 adder.
- Subtraction cancels leading bits, so the result needs left normalization. This block does it iteratively, one bit per clock.
- Sits beside the adder in the two-function calculator datapath and adds a valid/ready handshake on both sides.

---
 rtl/fp16_sequential_subtractor.sv | 164 ++++++++++++++++
 tb/tb_fp16_sequential_subtractor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fp16_sequential_subtractor.sv
// Multi-cycle FP16 magnitude subtractor (|A| - |B|), with one left-normalization step per clock.
// Define FPSUB_GUARD_BIT_EN to keep one guard bit from the alignment shift.
module fp16_sequential_subtractor #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_in,
    input  logic [EXP_W+MAN_W:0]   b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_zero,
    output logic                   flag_underflow
);
    localparam int MW = MAN_W + 1;
    localparam int FW = EXP_W + MAN_W;

    typedef enum logic [1:0] {IDLE, ALIGN, NORM, DONE} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    a_q, a_d, b_q, b_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [MW-1:0]    diff_q, diff_d;
    logic [FW:0]      result_q, result_d;
    logic             zero_q, zero_d;
    logic             uf_q, uf_d;

    // Operand sign bits carry no meaning for a magnitude subtraction.
    logic unused_sign;
    assign unused_sign = &{1'b0, a_in[FW], b_in[FW]};

    logic [EXP_W-1:0] ea, eb, e_big, e_small, d_amt;
    logic [MW-1:0]    ma, mb, m_big, m_small, align_diff;
    logic             b_gt_a, ins_bit;

    assign ea      = a_q[FW-1:MAN_W];
    assign eb      = b_q[FW-1:MAN_W];
    assign ma      = {1'b1, a_q[MAN_W-1:0]};
    assign mb      = {1'b1, b_q[MAN_W-1:0]};
    assign b_gt_a  = {eb, mb} > {ea, ma};
    assign e_big   = b_gt_a ? eb : ea;
    assign e_small = b_gt_a ? ea : eb;
    assign m_big   = b_gt_a ? mb : ma;
    assign m_small = b_gt_a ? ma : mb;
    assign d_amt   = e_big - e_small;

`ifdef FPSUB_GUARD_BIT_EN
    logic          guard_q, guard_d, align_guard;
    logic [MW:0]   small_ext, diff_ext;

    // Shifting {m_small,0} keeps the first dropped bit in the LSB.
    assign small_ext   = {m_small, 1'b0} >> d_amt;
    assign diff_ext    = {m_big, 1'b0} - small_ext;
    assign align_diff  = diff_ext[MW:1];
    assign align_guard = diff_ext[0];
    assign ins_bit     = guard_q;
`else
    assign align_diff  = m_big - (m_small >> d_amt);
    assign ins_bit     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        diff_d   = diff_q;
        result_d = result_q;
        zero_d   = zero_q;
        uf_d     = uf_q;
`ifdef FPSUB_GUARD_BIT_EN
        guard_d  = guard_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in[FW-1:0];
                    b_d     = b_in[FW-1:0];
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                sign_d  = b_gt_a;
                exp_d   = e_big;
                diff_d  = align_diff;
`ifdef FPSUB_GUARD_BIT_EN
                guard_d = align_guard;
`endif
                state_d = NORM;
            end
            NORM: begin
                if (diff_q == '0) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    state_d  = DONE;
                end else if (diff_q[MAN_W]) begin
                    result_d = {sign_q, exp_q, diff_q[MAN_W-1:0]};
                    state_d  = DONE;
                end else if (exp_q == EXP_W'(1)) begin
                    // Smallest normal exponent reached: flush instead of going subnormal.
                    result_d = '0;
                    uf_d     = 1'b1;
                    state_d  = DONE;
                end else begin
                    diff_d   = {diff_q[MAN_W-1:0], ins_bit};
                    exp_d    = exp_q - EXP_W'(1);
`ifdef FPSUB_GUARD_BIT_EN
                    guard_d  = 1'b0;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    zero_d  = 1'b0;
                    uf_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            diff_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            uf_q     <= 1'b0;
`ifdef FPSUB_GUARD_BIT_EN
            guard_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            diff_q   <= diff_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            uf_q     <= uf_d;
`ifdef FPSUB_GUARD_BIT_EN
            guard_q  <= guard_d;
`endif
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign result         = result_q;
    assign flag_zero      = zero_q;
    assign flag_underflow = uf_q;
endmodule

// File: tb/tb_fp16_sequential_subtractor.sv
// Directed-vector bench for fp16_sequential_subtractor: latency, result, flags and handshake.
module tb_fp16_sequential_subtractor;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_zero;
    logic        flag_underflow;

    int errors = 0;
    int checks = 0;

    fp16_sequential_subtractor #(.EXP_W(5), .MAN_W(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a_in           (a_in),
        .b_in           (b_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_zero      (flag_zero),
        .flag_underflow (flag_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        uf;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic run_op(input vec_t v);
        int          n;
        logic        got;
        logic [15:0] held;
        @(negedge clk);
        chk({v.name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a_in     = v.a;
        b_in     = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({v.name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk({v.name, ".out_valid_seen"}, 32'(got), 32'd1);
        chk({v.name, ".latency"}, 32'(n), 32'(v.lat));
        chk({v.name, ".result"}, 32'(result), 32'(v.res));
        chk({v.name, ".flag_zero"}, 32'(flag_zero), 32'(v.z));
        chk({v.name, ".flag_underflow"}, 32'(flag_underflow), 32'(v.uf));
        held = result;
        for (int i = 0; i < v.hold; i++) begin
            // New operands offered while busy must be ignored.
            a_in     = 16'h4200;
            b_in     = 16'h3C00;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk({v.name, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({v.name, ".hold_result"}, 32'(result), 32'(held));
            chk({v.name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({v.name, ".post_in_ready"}, 32'(in_ready), 32'd1);
        chk({v.name, ".post_flags"}, {30'd0, flag_zero, flag_underflow}, 32'd0);
        chk({v.name, ".post_result"}, 32'(result), 32'(held));
        $display("op %-16s a=%h b=%h -> result=%h z=%0d uf=%0d latency=%0d", v.name, v.a, v.b,
                 held, v.z, v.uf, n);
    endtask

    initial begin
        vecs[0] = '{"3.0-1.0",      16'h4200, 16'h3C00, 16'h4000, 1'b0, 1'b0, 2, 0};
        vecs[1] = '{"1.0-3.0",      16'h3C00, 16'h4200, 16'hC000, 1'b0, 1'b0, 2, 0};
        vecs[2] = '{"equal",        16'h4500, 16'h4500, 16'h0000, 1'b1, 1'b0, 2, 0};
        vecs[3] = '{"sign_ignored", 16'hC200, 16'hBC00, 16'h4000, 1'b0, 1'b0, 2, 0};
        vecs[4] = '{"shift_ge_11",  16'h7000, 16'h3C00, 16'h7000, 1'b0, 1'b0, 2, 0};
        vecs[5] = '{"32-1",         16'h5000, 16'h3C00, 16'h4FC0, 1'b0, 1'b0, 3, 0};
`ifdef FPSUB_GUARD_BIT_EN
        vecs[6] = '{"guard_bit",    16'h3C00, 16'h3801, 16'h37FE, 1'b0, 1'b0, 4, 0};
        vecs[7] = '{"uf_after_norm",16'h0C00, 16'h0BFF, 16'h0000, 1'b1, 1'b0, 2, 0};
`else
        vecs[6] = '{"guard_bit",    16'h3C00, 16'h3801, 16'h3800, 1'b0, 1'b0, 3, 0};
        vecs[7] = '{"uf_after_norm",16'h0C00, 16'h0BFF, 16'h0000, 1'b0, 1'b1, 4, 0};
`endif
        vecs[8] = '{"uf_direct",    16'h0401, 16'h0400, 16'h0000, 1'b0, 1'b1, 2, 0};
        vecs[9] = '{"ten_shifts",   16'h3C01, 16'h3C00, 16'h1400, 1'b0, 1'b0, 12, 5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 16'h0000;
        b_in      = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", 32'(result), 32'h0);
        chk("reset.flags", {30'd0, flag_zero, flag_underflow}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Abort a long normalization with reset, then confirm the block recovers.
        @(negedge clk);
        a_in     = 16'h3C01;
        b_in     = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort.busy_before", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.result", 32'(result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("op abort_in_norm    reset during NORM, in_ready=%0d out_valid=%0d", in_ready, out_valid);
        run_op(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
